mem_port_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-fetch refill path (requester 0) and the write-through data cache (requester 1). Requester 0 issues block reads. Requester 1 issues block reads (refill) or single-word writes (write-through). The block grants requesters round-robin, sequences multi-word bursts word by word on a req/ack memory handshake, and returns read data and done pulses to the owner. It sits between the cache front-ends and main memory; requesters stall their pipeline until their done pulse.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_rr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;
  localparam int   WORD_BYTES = 4;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick; the requester that did not own the port last wins a tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  input  logic i_owner,
  output logic o_grant,
  output logic o_any
);

  logic r_last_owner;

  // Reset favours the data cache as "last", so the fetch path wins first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_owner <= REQ_DCACHE;
    else if (i_update) r_last_owner <= i_owner;
  end

  always_comb begin
    o_any   = i_req0 | i_req1;
    o_grant = REQ_IFETCH;
    if (i_req0 && i_req1) o_grant = ~r_last_owner;
    else if (i_req1)      o_grant = REQ_DCACHE;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the fetch refill path and the write-through
// data cache, sequencing block reads and single-word writes on a req/ack handshake.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic              r1_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_we, w_we_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_gnt0, r_rvalid0, r_done0, r_gnt1, r_rvalid1, r_done1;
  logic              w_gnt0_nxt, w_rvalid0_nxt, w_done0_nxt;
  logic              w_gnt1_nxt, w_rvalid1_nxt, w_done1_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic [IDX_W-1:0]  r_rd_idx, w_rd_idx_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              w_arb_grant, w_arb_any, w_arb_update;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [IDX_W-1:0]  w_cnt_inc;
  logic [ADDR_W-1:0] w_next_addr;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (areset),
    .i_req0   (r0_req),
    .i_req1   (r1_req),
    .i_update (w_arb_update),
    .i_owner  (r_owner),
    .o_grant  (w_arb_grant),
    .o_any    (w_arb_any)
  );

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_next_addr = r_base + ADDR_W'(w_cnt_inc) * ADDR_W'(WORD_BYTES);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= IDLE;
      r_owner     <= REQ_IFETCH;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_gnt0      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_done0     <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_done1     <= 1'b0;
      r_rd_data   <= '0;
      r_rd_idx    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_we        <= w_we_nxt;
      r_wdata     <= w_wdata_nxt;
      r_base      <= w_base_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_rvalid0   <= w_rvalid0_nxt;
      r_done0     <= w_done0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_rvalid1   <= w_rvalid1_nxt;
      r_done1     <= w_done1_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_idx    <= w_rd_idx_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Every output is computed one cycle ahead here so the port sees only flop outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_we_nxt        = r_we;
    w_wdata_nxt     = r_wdata;
    w_base_nxt      = r_base;
    w_cnt_nxt       = r_cnt;
    w_rd_data_nxt   = r_rd_data;
    w_rd_idx_nxt    = r_rd_idx;
    w_gnt0_nxt      = 1'b0;
    w_rvalid0_nxt   = 1'b0;
    w_done0_nxt     = 1'b0;
    w_gnt1_nxt      = 1'b0;
    w_rvalid1_nxt   = 1'b0;
    w_done1_nxt     = 1'b0;
    w_mem_req_nxt   = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    w_arb_update    = 1'b0;
    w_sel_we        = (w_arb_grant == REQ_DCACHE) && r1_we;
    w_sel_addr      = (w_arb_grant == REQ_DCACHE) ? r1_addr : r0_addr;

    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_state_nxt     = XFER;
          w_owner_nxt     = w_arb_grant;
          w_we_nxt        = w_sel_we;
          w_wdata_nxt     = (w_arb_grant == REQ_DCACHE) ? r1_wdata : '0;
          w_base_nxt      = w_sel_addr & (w_sel_we ? WORD_MASK : BLOCK_MASK);
          w_cnt_nxt       = '0;
          w_gnt0_nxt      = (w_arb_grant == REQ_IFETCH);
          w_gnt1_nxt      = (w_arb_grant == REQ_DCACHE);
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = w_sel_we;
          w_mem_addr_nxt  = w_base_nxt;
          w_mem_wdata_nxt = w_wdata_nxt;
        end
      end
      XFER: begin
        w_gnt0_nxt      = (r_owner == REQ_IFETCH);
        w_gnt1_nxt      = (r_owner == REQ_DCACHE);
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = r_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_wdata;
        if (mem_ack) begin
          if (!r_we) begin
            w_rd_data_nxt = mem_rdata;
            w_rd_idx_nxt  = r_cnt;
            w_rvalid0_nxt = (r_owner == REQ_IFETCH);
            w_rvalid1_nxt = (r_owner == REQ_DCACHE);
          end
          if (r_we || (r_cnt == LAST_IDX)) begin
            w_state_nxt     = DONE;
            w_mem_req_nxt   = 1'b0;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = '0;
            w_mem_wdata_nxt = '0;
            w_done0_nxt     = (r_owner == REQ_IFETCH);
            w_done1_nxt     = (r_owner == REQ_DCACHE);
          end else begin
            w_cnt_nxt      = w_cnt_inc;
            w_mem_addr_nxt = w_next_addr;
          end
        end
      end
      DONE: begin
        w_state_nxt  = IDLE;
        w_arb_update = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign r0_gnt    = r_gnt0;
  assign r0_rvalid = r_rvalid0;
  assign r0_done   = r_done0;
  assign r1_gnt    = r_gnt1;
  assign r1_rvalid = r_rvalid1;
  assign r1_done   = r_done1;
  assign rd_data   = r_rd_data;
  assign rd_idx    = r_rd_idx;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple ack-delay memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        r0_req = 1'b0;
  logic [31:0] r0_addr = '0;
  logic        r0_gnt, r0_rvalid, r0_done;
  logic        r1_req = 1'b0;
  logic        r1_we = 1'b0;
  logic [31:0] r1_addr = '0;
  logic [31:0] r1_wdata = '0;
  logic        r1_gnt, r1_rvalid, r1_done;
  logic [31:0] rd_data;
  logic [1:0]  rd_idx;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int   n_pass = 0;
  int   n_total = 0;
  int   ack_delay = 0;
  logic ack_force = 1'b0;
  int   wait_cnt = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .areset    (areset),
    .r0_req    (r0_req),
    .r0_addr   (r0_addr),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_done   (r0_done),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_done   (r1_done),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory model: read data equals the address; ack after ack_delay wait cycles.
  assign mem_rdata = mem_addr;
  assign mem_ack   = ack_force | (mem_req && (wait_cnt == ack_delay));

  always @(posedge clk or posedge areset) begin
    if (areset)                 wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                        wait_cnt <= 0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_done(input logic which, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((which ? r1_done : r0_done) === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done} !== 6'b0)
      $display("[TB] FAIL reset_ctrl: got %b want 000000", {r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done});
    else n_pass++;
    n_total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'b0)
      $display("[TB] FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if ({rd_data, rd_idx} !== 34'b0)
      $display("[TB] FAIL reset_rd: got data=%h idx=%0d want 0/0", rd_data, rd_idx);
    else n_pass++;
    areset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({mem_req, r0_gnt, r1_gnt} !== 3'b0)
      $display("[TB] FAIL post_reset_idle: got %b want 000", {mem_req, r0_gnt, r1_gnt});
    else n_pass++;
  endtask

  task automatic test_r0_read();
    logic [31:0] exp_addr;
    r0_addr = 32'h0000_0104;
    r0_req  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        exp_addr = 32'h100 + 32'(4 * (k - 1));
        n_total++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, exp_addr})
          $display("[TB] FAIL r0rd_mem%0d: got req=%b we=%b addr=%h want 1/0/%h", k, mem_req, mem_we, mem_addr, exp_addr);
        else n_pass++;
      end else begin
        n_total++;
        if (mem_req !== 1'b0)
          $display("[TB] FAIL r0rd_memreq_drop: got %b want 0", mem_req);
        else n_pass++;
      end
      n_total++;
      if ({r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done} !== {1'b1, (k >= 2), (k == 5), 3'b000})
        $display("[TB] FAIL r0rd_ctrl%0d: got %b want %b", k, {r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done},
                 {1'b1, (k >= 2), (k == 5), 3'b000});
      else n_pass++;
      if (k >= 2) begin
        exp_addr = 32'h100 + 32'(4 * (k - 2));
        n_total++;
        if ({rd_idx, rd_data} !== {2'(k - 2), exp_addr})
          $display("[TB] FAIL r0rd_data%0d: got idx=%0d data=%h want %0d/%h", k, rd_idx, rd_data, k - 2, exp_addr);
        else n_pass++;
      end
    end
    r0_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r0_rvalid, r0_done, mem_req} !== 4'b0)
      $display("[TB] FAIL r0rd_after: got %b want 0000", {r0_gnt, r0_rvalid, r0_done, mem_req});
    else n_pass++;
  endtask

  task automatic test_r1_write();
    r1_we    = 1'b1;
    r1_addr  = 32'h0000_0203;
    r1_wdata = 32'hDEAD_BEEF;
    r1_req   = 1'b1;
    @(negedge clk);
    n_total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF})
      $display("[TB] FAIL r1wr_mem: got req=%b we=%b addr=%h wdata=%h want 1/1/00000200/deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if ({r1_gnt, r1_rvalid, r1_done, r0_gnt} !== 4'b1000)
      $display("[TB] FAIL r1wr_xfer_ctrl: got %b want 1000", {r1_gnt, r1_rvalid, r1_done, r0_gnt});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r1_gnt, r1_rvalid, r1_done, mem_req} !== 4'b1010)
      $display("[TB] FAIL r1wr_done: got %b want 1010", {r1_gnt, r1_rvalid, r1_done, mem_req});
    else n_pass++;
    r1_req = 1'b0;
    r1_we  = 1'b0;
    @(negedge clk);
    n_total++;
    if ({r1_gnt, r1_rvalid, r1_done} !== 3'b000)
      $display("[TB] FAIL r1wr_after: got %b want 000", {r1_gnt, r1_rvalid, r1_done});
    else n_pass++;
  endtask

  task automatic test_contention();
    logic ok;
    r0_addr = 32'h0000_0400;
    r1_addr = 32'h0000_0300;
    r1_we   = 1'b0;
    r0_req  = 1'b1;
    r1_req  = 1'b1;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r1_gnt, mem_addr} !== {2'b10, 32'h400})
      $display("[TB] FAIL cont_first_r0: got gnt=%b addr=%h want 10/00000400", {r0_gnt, r1_gnt}, mem_addr);
    else n_pass++;
    wait_done(1'b0, ok);
    n_total++;
    if (!ok) $display("[TB] FAIL cont_r0_done: got timeout want r0_done");
    else n_pass++;
    r0_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r1_gnt} !== 2'b00)
      $display("[TB] FAIL cont_gap: got gnt=%b want 00", {r0_gnt, r1_gnt});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r1_gnt, mem_addr} !== {2'b01, 32'h300})
      $display("[TB] FAIL cont_then_r1: got gnt=%b addr=%h want 01/00000300", {r0_gnt, r1_gnt}, mem_addr);
    else n_pass++;
    wait_done(1'b1, ok);
    n_total++;
    if (!ok) $display("[TB] FAIL cont_r1_done: got timeout want r1_done");
    else n_pass++;
    r1_req = 1'b0;
    @(negedge clk);

    r0_req = 1'b1;
    r1_req = 1'b1;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r1_gnt} !== 2'b10)
      $display("[TB] FAIL cont_repeat_r0: got gnt=%b want 10", {r0_gnt, r1_gnt});
    else n_pass++;
    wait_done(1'b0, ok);
    r0_req = 1'b0;
    wait_done(1'b1, ok);
    n_total++;
    if (!ok) $display("[TB] FAIL cont_repeat_r1_done: got timeout want r1_done");
    else n_pass++;
    r1_req = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 2; n++) begin
      r0_req = 1'b1;
      wait_done(1'b0, ok);
      n_total++;
      if (!ok) $display("[TB] FAIL cont_solo_r0_%0d: got timeout want r0_done", n);
      else n_pass++;
      r0_req = 1'b0;
      @(negedge clk);
    end
    r0_req = 1'b1;
    r1_req = 1'b1;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r1_gnt} !== 2'b01)
      $display("[TB] FAIL cont_rr_r1: got gnt=%b want 01", {r0_gnt, r1_gnt});
    else n_pass++;
    wait_done(1'b1, ok);
    r1_req = 1'b0;
    wait_done(1'b0, ok);
    n_total++;
    if (!ok) $display("[TB] FAIL cont_rr_r0_done: got timeout want r0_done");
    else n_pass++;
    r0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_addr;
    logic        exp_rv;
    ack_delay = 3;
    r1_we     = 1'b0;
    r1_addr   = 32'h0000_0508;
    r1_req    = 1'b1;
    for (int j = 0; j < 17; j++) begin
      @(negedge clk);
      if (j < 16) begin
        exp_addr = 32'h500 + 32'(4 * (j / 4));
        n_total++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, exp_addr})
          $display("[TB] FAIL ws_hold%0d: got req=%b we=%b addr=%h want 1/0/%h", j, mem_req, mem_we, mem_addr, exp_addr);
        else n_pass++;
      end
      exp_rv = (j >= 4) && (j % 4 == 0);
      n_total++;
      if ({r1_rvalid, r1_done} !== {exp_rv, (j == 16)})
        $display("[TB] FAIL ws_ctrl%0d: got rvalid/done=%b want %b", j, {r1_rvalid, r1_done}, {exp_rv, (j == 16)});
      else n_pass++;
      if (exp_rv) begin
        exp_addr = 32'h500 + 32'(4 * (j / 4 - 1));
        n_total++;
        if ({rd_idx, rd_data} !== {2'(j / 4 - 1), exp_addr})
          $display("[TB] FAIL ws_data%0d: got idx=%0d data=%h want %0d/%h", j, rd_idx, rd_data, j / 4 - 1, exp_addr);
        else n_pass++;
      end
    end
    r1_req    = 1'b0;
    ack_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    logic ok;
    r0_addr = 32'h0000_0604;
    r0_req  = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({r0_rvalid, rd_idx} !== {1'b1, 2'd1})
      $display("[TB] FAIL rst_mid_pre: got rvalid=%b idx=%0d want 1/1", r0_rvalid, rd_idx);
    else n_pass++;
    #2 areset = 1'b1;
    #1;
    n_total++;
    if ({r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done, mem_req, mem_we} !== 8'b0)
      $display("[TB] FAIL rst_mid_ctrl: got %b want 00000000", {r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done, mem_req, mem_we});
    else n_pass++;
    n_total++;
    if ({mem_addr, rd_data, rd_idx} !== 66'b0)
      $display("[TB] FAIL rst_mid_data: got addr=%h data=%h idx=%0d want 0", mem_addr, rd_data, rd_idx);
    else n_pass++;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, mem_req, mem_addr} !== {2'b11, 32'h600})
      $display("[TB] FAIL rst_restart_addr: got gnt=%b req=%b addr=%h want 1/1/00000600", r0_gnt, mem_req, mem_addr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({r0_rvalid, rd_idx, rd_data} !== {1'b1, 2'd0, 32'h600})
      $display("[TB] FAIL rst_restart_idx: got rvalid=%b idx=%0d data=%h want 1/0/00000600", r0_rvalid, rd_idx, rd_data);
    else n_pass++;
    wait_done(1'b0, ok);
    n_total++;
    if (!ok) $display("[TB] FAIL rst_restart_done: got timeout want r0_done");
    else n_pass++;
    r0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    logic [31:0] exp_addr;
    ack_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++;
      if ({r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done, mem_req} !== 7'b0)
        $display("[TB] FAIL spur_idle%0d: got %b want 0000000", k, {r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done, mem_req});
      else n_pass++;
    end
    r0_addr = 32'h0000_070C;
    r0_req  = 1'b1;
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r0_rvalid, mem_addr} !== {2'b10, 32'h700})
      $display("[TB] FAIL spur_start: got gnt=%b rvalid=%b addr=%h want 1/0/00000700", r0_gnt, r0_rvalid, mem_addr);
    else n_pass++;
    r0_req = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      exp_addr = 32'h700 + 32'(4 * (k - 2));
      n_total++;
      if ({r0_rvalid, r0_done, rd_idx, rd_data} !== {1'b1, (k == 5), 2'(k - 2), exp_addr})
        $display("[TB] FAIL spur_burst%0d: got rvalid=%b done=%b idx=%0d data=%h want 1/%b/%0d/%h",
                 k, r0_rvalid, r0_done, rd_idx, rd_data, (k == 5), k - 2, exp_addr);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({r0_gnt, r0_rvalid, r0_done, mem_req} !== 4'b0)
      $display("[TB] FAIL spur_after: got %b want 0000", {r0_gnt, r0_rvalid, r0_done, mem_req});
    else n_pass++;
    ack_force = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r0_read();
    test_r1_write();
    test_contention();
    test_wait_states();
    test_reset_mid_burst();
    test_spurious_ack();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
